// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - state encoding and constants shared by the instruction loader
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } loader_state_e;

  localparam int unsigned HDR_BYTES         = 2;
  localparam int unsigned WORD_BYTES        = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles serial bytes into little-endian 32-bit words
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt_q;
  logic [31:0]   word_q;

  // Shifting in from the top leaves the first byte of a word in bits [7:0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (load_clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_en) begin
      cnt_q  <= cnt_q + CW'(1);
      word_q <= {byte_in, word_q[31:8]};
    end
  end

  assign word      = word_q;
  assign word_full = byte_en && (cnt_q == CW'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - serial instruction loader; INST_LOADER_CHECKSUM_EN adds a trailing XOR check byte
module inst_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam loader_state_e S_FINISH = S_CHECK;
  logic [7:0] xor_q, xor_d;
`else
  localparam loader_state_e S_FINISH = S_DONE;
`endif

  loader_state_e state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   index_q, index_d;
  logic [15:0]   hdr_count;
  logic          accept;
  logic          pk_clear;
  logic          pk_en;
  logic          word_full;
  logic [31:0]   word;

  assign accept = byte_valid && byte_ready;
  assign pk_en  = accept && (state_q == S_DATA);

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .load_clear (pk_clear),
    .byte_en    (pk_en),
    .byte_in    (byte_in),
    .word       (word),
    .word_full  (word_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      index_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    pk_clear  = 1'b0;
    hdr_count = {byte_in, count_q[7:0]};
`ifdef INST_LOADER_CHECKSUM_EN
    xor_d     = accept ? (xor_q ^ byte_in) : xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_CNT_LO;
          count_d  = '0;
          index_d  = '0;
          pk_clear = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_d    = '0;
`endif
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          count_d = {8'h00, byte_in};
          state_d = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          count_d = hdr_count;
          if ({1'b0, hdr_count} > DEPTH_W)
            state_d = S_ERR;
          else if (hdr_count == 16'd0)
            state_d = S_FINISH;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_full)
          state_d = S_WRITE;
      end
      S_WRITE: begin
        index_d = index_q + 16'd1;
        state_d = (index_d == count_q) ? S_FINISH : S_DATA;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        // Compare against the XOR of everything before this byte.
        if (accept)
          state_d = (byte_in == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready  = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
  assign mem_wr_en   = (state_q == S_WRITE);
  assign mem_addr    = BASE_ADDR + {14'd0, index_q, 2'b00};
  assign mem_wr_data = word;
  assign cpu_reset   = (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00400000, byte address of the first loaded word.
REQ-002 Parameter DEPTH, default 256, capacity in 32-bit words.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins a load.
REQ-006 byte_in  in  8  serial payload byte.
REQ-007 byte_valid  in  1  byte_in is valid this cycle.
REQ-008 byte_ready  out  1  loader accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-009 mem_wr_en  out  1  instruction-memory write strobe.
REQ-010 mem_addr  out  32  word-aligned byte address for the write.
REQ-011 mem_wr_data  out  32  assembled instruction word.
REQ-012 cpu_reset  out  1  holds the arithmetic machine in reset while 1.
REQ-013 done  out  1  load completed successfully.
REQ-014 error  out  1  load aborted.

Function
REQ-015 States SHALL be IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHECK (macro only), DONE, ERR.
REQ-016 start SHALL be honoured in IDLE, DONE and ERR: next state CNT_LO, word index cleared, done and error cleared, cpu_reset set to 1.
REQ-017 start SHALL be ignored in CNT_LO, CNT_HI, DATA, WRITE and CHECK.
REQ-018 byte_ready SHALL be 1 in CNT_LO, CNT_HI, DATA and CHECK, and 0 in every other state.
REQ-019 Header: the first byte is count[7:0] and the second byte is count[15:8], where count is the number of words.
REQ-020 After CNT_HI, the next state SHALL be:
  - ERR if count > DEPTH;
  - DONE (or CHECK with the macro) if count == 0;
  - DATA otherwise.
REQ-021 In DATA, each word is 4 bytes, little-endian: the first byte goes to bits [7:0].
REQ-022 Acceptance of the 4th byte of a word SHALL move the FSM to WRITE. In WRITE, for exactly one cycle:
  - mem_wr_en = 1;
  - mem_addr = BASE_ADDR + 4*index;
  - mem_wr_data = the assembled word.
REQ-023 Write latency SHALL be one cycle after acceptance of the 4th byte, with byte_ready = 0 during WRITE.
REQ-024 After WRITE, index increments; the next state SHALL be DONE (or CHECK) if index == count, otherwise DATA.
REQ-025 A byte_valid gap of any length SHALL stall the FSM without losing partially assembled bytes.
REQ-026 In DONE: done = 1 and cpu_reset = 0, held until the next start or reset.
REQ-027 In ERR: error = 1 and cpu_reset = 1, held until the next start or reset.
REQ-028 mem_wr_en SHALL be 0 in every state except WRITE; mem_addr and mem_wr_data are don't-care when mem_wr_en = 0.
REQ-029 The index and count registers SHALL be 16 bits wide; address arithmetic SHALL be 32-bit, with any carry beyond bit 31 discarded.

Reset
REQ-030 Asserting reset at any time, including mid-load, SHALL immediately set:
  - state = IDLE, with index, count and the assembled word cleared;
  - mem_wr_en = 0, byte_ready = 0, done = 0, error = 0;
  - cpu_reset = 1.
REQ-031 No memory write SHALL occur in the cycle in which reset deasserts.

Configuration
REQ-032 Macro INST_LOADER_CHECKSUM_EN:
  - When defined: the loader keeps a running XOR of all header and data bytes. After the last word (or after a zero count), CHECK accepts one byte. The next state is DONE if that byte equals the running XOR, otherwise ERR.
  - When undefined: CHECK and the XOR register are absent, and the FSM goes directly to DONE.

Structure
REQ-033 Package loader_pkg SHALL hold the state encoding, HDR_BYTES = 2, WORD_BYTES = 4, and the default BASE_ADDR.
REQ-034 Sub-module byte_packer SHALL hold the 2-bit byte counter and the 32-bit shift/assembly register. It exposes a "word_full" pulse and clears itself on load_clear.

Verification
REQ-035 Count 2, bytes 78 56 34 12 EF BE AD DE -> writes 12345678@00400000 and DEADBEEF@00400004; done = 1; cpu_reset falls one cycle after the second write.
REQ-036 Count 0 -> DONE immediately after CNT_HI, with no mem_wr_en pulse.
REQ-037 Count DEPTH+1 (0x0101) -> ERR after the second header byte, error = 1, no writes, cpu_reset stays 1.
REQ-038 byte_valid toggling 1/0 every cycle during DATA -> identical writes to the back-to-back case; byte_ready = 0 exactly in each WRITE cycle.
REQ-039 Reset asserted after 2 bytes of the first word, then start and a fresh count-1 stream -> a single correct write at 00400000; no stale bytes in the written word.
REQ-040 With INST_LOADER_CHECKSUM_EN and a count-1 stream 01 00 AA BB CC DD:
  - checksum byte 0x01 -> DONE;
  - checksum byte 0x00 -> ERR, with the word still written.
